// File: rtl/soc_step_ctrl.sv
// Button-driven reset / clock-enable sequencer for Soc_Mips: single-step, free-run, run-N-then-halt.
// Define SOC_STEP_DEBOUNCE_EN to insert the per-button debounce filter behind the synchronizers.
module soc_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RST_HOLD        = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             btn_reset,
  input  logic [CNT_W-1:0] run_limit,
  output logic             cpu_rst,
  output logic             cpu_ce,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  if (DEBOUNCE_CYCLES < 1 || RST_HOLD < 1) begin : g_bad_params
    $error("soc_step_ctrl: DEBOUNCE_CYCLES and RST_HOLD must be at least 1");
  end

  // Buttons are handled as a 3-bit vector: bit 0 step, bit 1 run, bit 2 reset.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] level;
  logic [2:0] level_d;
  logic [2:0] press;

  assign raw = {btn_reset, btn_run, btn_step};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef SOC_STEP_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      accepted;

  // A new level is taken only after DEBOUNCE_CYCLES consecutive samples that disagree
  // with the accepted one; any sample agreeing with it restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == accepted[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          accepted[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = accepted;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= '0;
      press   <= '0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

  // Priority: reset over run over step; losing presses are simply dropped.
  logic p_rst;
  logic p_run;
  logic p_step;

  assign p_rst  = press[2];
  assign p_run  = press[1] & ~press[2];
  assign p_step = press[0] & ~press[1] & ~press[2];

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nx;
  logic [CNT_W-1:0]  count_inc;
  logic              limit_on;
  logic              at_limit;
  logic              inc_at_limit;

  assign count_inc    = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
  assign limit_on     = (run_limit != '0);
  assign at_limit     = limit_on && (cycle_count >= run_limit);
  assign inc_at_limit = limit_on && (count_inc >= run_limit);

  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    if (p_rst) begin
      state_nx = S_RESET;
      hold_nx  = '0;
    end else begin
      case (state)
        S_RESET: begin
          if (hold == HOLD_LAST) state_nx = S_IDLE;
          else                   hold_nx  = hold + 1'b1;
        end
        S_IDLE: begin
          if (p_run)       state_nx = at_limit ? S_HALT : S_RUN;
          else if (p_step) state_nx = S_STEP;
        end
        S_STEP: state_nx = S_IDLE;
        S_RUN: begin
          // The pulse of this cycle is already issued; leave once it reaches the limit.
          if (p_run)             state_nx = S_IDLE;
          else if (inc_at_limit) state_nx = S_HALT;
        end
        S_HALT: ;
        default: begin
          state_nx = S_RESET;
          hold_nx  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RESET;
      hold        <= '0;
      cpu_rst     <= 1'b1;
      cpu_ce      <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state   <= state_nx;
      hold    <= hold_nx;
      cpu_rst <= (state_nx == S_RESET);
      cpu_ce  <= (state_nx == S_STEP) || (state_nx == S_RUN);
      running <= (state_nx == S_RUN);
      halted  <= (state_nx == S_HALT);
      if (state_nx == S_RESET) cycle_count <= '0;
      else if (cpu_ce)         cycle_count <= count_inc;
    end
  end

endmodule

// File: tb/tb_soc_step_ctrl.sv
// Self-checking bench for soc_step_ctrl: directed scenarios plus random button traffic,
// all checked against a behavioural model of the button, run-limit and reset rules.
`timescale 1ns/1ps
module tb_soc_step_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 4;
  localparam int W    = 16;
`ifdef SOC_STEP_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int STEP_LAT = DEB_EN ? DEB + 3 : 3;
  localparam int MAXCNT   = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_step;
  logic         btn_run;
  logic         btn_reset;
  logic [W-1:0] run_limit;
  logic         cpu_rst;
  logic         cpu_ce;
  logic         running;
  logic         halted;
  logic [W-1:0] cycle_count;
  logic [W+3:0] obs;

  int n_cmp   = 0;
  int n_err   = 0;
  int ce_seen = 0;

  soc_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .RST_HOLD(HOLD), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .btn_run(btn_run), .btn_reset(btn_reset),
    .run_limit(run_limit), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .running(running),
    .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  assign obs = {cpu_rst, cpu_ce, running, halted, cycle_count};

  // Behavioural model: what the SoC should see, derived from the operating rules.
  typedef enum int {M_RESET, M_IDLE, M_STEP, M_RUN, M_HALT} mode_t;
  mode_t    m_mode;
  int       m_hold;
  int       m_count;
  bit [2:0] m_r1, m_r2, m_acc, m_acc_old, m_pulse;
  int       m_run [3];

  function automatic void model_reset();
    m_mode = M_RESET; m_hold = 0; m_count = 0;
    m_r1 = '0; m_r2 = '0; m_acc = '0; m_acc_old = '0; m_pulse = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endfunction

  function automatic int bump(input int c);
    return (c >= MAXCNT) ? c : c + 1;
  endfunction

  function automatic void model_step();
    bit [2:0] raw;
    bit [2:0] samp;
    int       lim;
    raw = {btn_reset, btn_run, btn_step};
    lim = int'(run_limit);
    if (m_pulse[2]) begin
      m_mode = M_RESET; m_hold = 0; m_count = 0;
    end else begin
      case (m_mode)
        M_RESET: begin
          m_hold++;
          if (m_hold == HOLD) m_mode = M_IDLE;
        end
        M_IDLE: begin
          if (m_pulse[1])      m_mode = (lim != 0 && m_count >= lim) ? M_HALT : M_RUN;
          else if (m_pulse[0]) m_mode = M_STEP;
        end
        M_STEP: begin
          m_count = bump(m_count);
          m_mode  = M_IDLE;
        end
        M_RUN: begin
          m_count = bump(m_count);
          if (m_pulse[1])                    m_mode = M_IDLE;
          else if (lim != 0 && m_count >= lim) m_mode = M_HALT;
        end
        default: ;
      endcase
    end
    samp      = m_r2;
    m_r2      = m_r1;
    m_r1      = raw;
    m_pulse   = m_acc & ~m_acc_old;
    m_acc_old = m_acc;
    if (DEB_EN) begin
      for (int i = 0; i < 3; i++) begin
        if (samp[i] != m_acc[i]) m_run[i]++;
        else                     m_run[i] = 0;
        if (m_run[i] >= DEB) begin
          m_acc[i] = samp[i];
          m_run[i] = 0;
        end
      end
    end else begin
      m_acc = m_r2;
    end
  endfunction

  function automatic logic [W+3:0] model_vec();
    return {m_mode == M_RESET, (m_mode == M_STEP) || (m_mode == M_RUN),
            m_mode == M_RUN, m_mode == M_HALT, W'(m_count)};
  endfunction

  task automatic cyc();
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    if (cpu_ce) ce_seen++;
  endtask

  task automatic apply_reset();
    rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0; btn_reset = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    repeat (HOLD + 2) cyc();
  endtask

  task automatic press(input int which, input int hi, input int lo);
    case (which)
      0: btn_step = 1'b1;
      1: btn_run  = 1'b1;
      default: btn_reset = 1'b1;
    endcase
    repeat (hi) cyc();
    btn_step = 1'b0; btn_run = 1'b0; btn_reset = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic test_reset();
    logic [W+3:0] exp_rst;
    exp_rst = {4'b1000, {W{1'b0}}};
    rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0; btn_reset = 1'b0; run_limit = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (obs !== exp_rst) begin
        n_err++; $display("[TB] FAIL reset_values: got %h expected %h", obs, exp_rst);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_cmp++;
      if (cpu_rst !== 1'(i < 3)) begin
        n_err++; $display("[TB] FAIL rst_hold cycle %0d: got %b expected %b", i, cpu_rst, i < 3);
      end
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++; $display("[TB] FAIL rst_model cycle %0d: got %h expected %h", i, obs, model_vec());
      end
    end
    n_cmp++;
    if ({cpu_ce, running, halted, cycle_count} !== '0) begin
      n_err++; $display("[TB] FAIL rst_idle: got ce=%b run=%b halt=%b cnt=%0d expected all zero",
                        cpu_ce, running, halted, cycle_count);
    end
  endtask

  task automatic test_step_hold();
    int first;
    int base;
    first = -1;
    base  = ce_seen;
    btn_step = 1'b1;
    for (int i = 0; i < 35; i++) begin
      if (i == 20) btn_step = 1'b0;
      cyc();
      if (cpu_ce && first < 0) first = i;
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++; $display("[TB] FAIL step_model cycle %0d: got %h expected %h", i, obs, model_vec());
      end
    end
    n_cmp++;
    if (ce_seen - base != 1) begin
      n_err++; $display("[TB] FAIL step_pulses: got %0d expected 1", ce_seen - base);
    end
    n_cmp++;
    if (first != STEP_LAT) begin
      n_err++; $display("[TB] FAIL step_latency: got %0d expected %0d", first, STEP_LAT);
    end
    n_cmp++;
    if (cycle_count !== W'(1)) begin
      n_err++; $display("[TB] FAIL step_count: got %0d expected 1", cycle_count);
    end
  endtask

  task automatic test_run_limit();
    int base;
    int streak;
    int best;
    apply_reset();
    run_limit = W'(14);
    base = ce_seen; streak = 0; best = 0;
    btn_run = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) btn_run = 1'b0;
      cyc();
      streak = cpu_ce ? streak + 1 : 0;
      if (streak > best) best = streak;
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++; $display("[TB] FAIL limit_model cycle %0d: got %h expected %h", i, obs, model_vec());
      end
    end
    n_cmp++;
    if (ce_seen - base != 14 || best != 14) begin
      n_err++; $display("[TB] FAIL limit_pulses: got %0d pulses (longest run %0d) expected 14 contiguous",
                        ce_seen - base, best);
    end
    n_cmp++;
    if ({halted, running} !== 2'b10 || cycle_count !== W'(14)) begin
      n_err++; $display("[TB] FAIL limit_halt: got halted=%b running=%b cnt=%0d expected 1 0 14",
                        halted, running, cycle_count);
    end
    base = ce_seen;
    btn_step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) btn_step = 1'b0;
      cyc();
    end
    n_cmp++;
    if (ce_seen - base != 0 || halted !== 1'b1) begin
      n_err++; $display("[TB] FAIL halt_ignores_step: got %0d pulses halted=%b expected 0 pulses halted=1",
                        ce_seen - base, halted);
    end
  endtask

  task automatic test_bounce();
    int base;
    int want;
    apply_reset();
    run_limit = '0;
    base = ce_seen;
    want = DEB_EN ? 0 : 4;
    for (int i = 0; i < 36; i++) begin
      btn_step = (i < 16) ? (((i >> 1) & 1) == 0) : 1'b0;
      cyc();
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++; $display("[TB] FAIL bounce_model cycle %0d: got %h expected %h", i, obs, model_vec());
      end
    end
    n_cmp++;
    if (ce_seen - base != want || cycle_count !== W'(want)) begin
      n_err++; $display("[TB] FAIL bounce_pulses: got %0d pulses cnt=%0d expected %0d",
                        ce_seen - base, cycle_count, want);
    end
  endtask

  task automatic test_reset_during_run();
    int rst_cycles;
    int ce_after;
    bit rst_started;
    apply_reset();
    run_limit = '0;
    press(1, 5, 30);
    n_cmp++;
    if (running !== 1'b1 || cpu_ce !== 1'b1) begin
      n_err++; $display("[TB] FAIL free_run: got running=%b ce=%b expected 1 1", running, cpu_ce);
    end
    rst_cycles = 0; ce_after = 0; rst_started = 1'b0;
    btn_reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i == 10) btn_reset = 1'b0;
      cyc();
      if (cpu_rst) begin
        rst_cycles++;
        rst_started = 1'b1;
      end
      if (rst_started && cpu_ce) ce_after++;
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++; $display("[TB] FAIL runrst_model cycle %0d: got %h expected %h", i, obs, model_vec());
      end
    end
    n_cmp++;
    if (rst_cycles != HOLD || ce_after != 0) begin
      n_err++; $display("[TB] FAIL runrst_hold: got rst cycles=%0d ce after=%0d expected %0d and 0",
                        rst_cycles, ce_after, HOLD);
    end
    n_cmp++;
    if ({cpu_rst, cpu_ce, running, halted, cycle_count} !== '0) begin
      n_err++; $display("[TB] FAIL runrst_idle: got %h expected 0", obs);
    end
  endtask

  task automatic test_coincident();
    bit run_seen;
    bit rst_seen;
    apply_reset();
    run_seen = 1'b0; rst_seen = 1'b0;
    btn_run = 1'b1; btn_reset = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i == 8) begin
        btn_run = 1'b0; btn_reset = 1'b0;
      end
      cyc();
      if (running) run_seen = 1'b1;
      if (cpu_rst) rst_seen = 1'b1;
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++; $display("[TB] FAIL coinc_model cycle %0d: got %h expected %h", i, obs, model_vec());
      end
    end
    n_cmp++;
    if (run_seen || !rst_seen) begin
      n_err++; $display("[TB] FAIL coinc_priority: got running seen=%b reset seen=%b expected 0 1",
                        run_seen, rst_seen);
    end
  endtask

  task automatic test_limit_override();
    int base;
    apply_reset();
    run_limit = '0;
    repeat (3) press(0, 8, 10);
    n_cmp++;
    if (cycle_count !== W'(3)) begin
      n_err++; $display("[TB] FAIL override_setup: got cnt=%0d expected 3", cycle_count);
    end
    run_limit = W'(2);
    press(0, 8, 10);
    n_cmp++;
    if (cycle_count !== W'(4) || halted !== 1'b0) begin
      n_err++; $display("[TB] FAIL override_step: got cnt=%0d halted=%b expected 4 0", cycle_count, halted);
    end
    base = ce_seen;
    press(1, 8, 10);
    n_cmp++;
    if (halted !== 1'b1 || ce_seen - base != 0 || cycle_count !== W'(4)) begin
      n_err++; $display("[TB] FAIL override_run: got halted=%b pulses=%0d cnt=%0d expected 1 0 4",
                        halted, ce_seen - base, cycle_count);
    end
    n_cmp++;
    if (obs !== model_vec()) begin
      n_err++; $display("[TB] FAIL override_model: got %h expected %h", obs, model_vec());
    end
  endtask

  task automatic test_random();
    int left [3];
    apply_reset();
    for (int b = 0; b < 3; b++) left[b] = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left[0] == 0) begin
        btn_step = ~btn_step; left[0] = $urandom_range(14, 1);
      end
      if (left[1] == 0) begin
        btn_run = ~btn_run; left[1] = $urandom_range(20, 1);
      end
      if (left[2] == 0) begin
        if (btn_reset)                        btn_reset = 1'b0;
        else if ($urandom_range(199, 0) == 0) btn_reset = 1'b1;
        left[2] = btn_reset ? $urandom_range(10, 1) : 1;
      end
      if ($urandom_range(149, 0) == 0)
        run_limit = ($urandom_range(3, 0) == 0) ? '0 : W'($urandom_range(40, 1));
      for (int b = 0; b < 3; b++) left[b]--;
      cyc();
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++; $display("[TB] FAIL random_model cycle %0d: got %h expected %h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_step_hold();
    test_run_limit();
    test_bounce();
    test_reset_during_run();
    test_coincident();
    test_limit_override();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
